// File: rtl/rom_load_pkg.sv
// Shared types and ROM geometry for the Lunar Lander ROM download path.
package rom_load_pkg;

   localparam int unsigned LLANDER_PROG_SIZE = 8192;
   localparam int unsigned LLANDER_VEC_SIZE  = 2048;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      RUN    = 3'd3,
      ERROR  = 3'd4
   } state_t;

endpackage

// File: rtl/rom_region_decode.sv
// Splits a download byte address into program/vector ROM hits and a region-local address.
module rom_region_decode #(
   parameter int unsigned PROG_SIZE = 8192,
   parameter int unsigned VEC_SIZE  = 2048
) (
   input  logic [15:0] addr,
   output logic        prog_hit,
   output logic        vec_hit,
   output logic [12:0] local_addr
);

   always_comb begin
      prog_hit   = ({16'd0, addr} < PROG_SIZE);
      vec_hit    = !prog_hit && ({16'd0, addr} < (PROG_SIZE + VEC_SIZE));
      local_addr = prog_hit ? 13'(addr) : 13'(addr - 16'(PROG_SIZE));
   end

endmodule

// File: rtl/rom_load_ctrl.sv
// Routes download bytes into the program/vector ROMs and holds the core in reset until a
// complete image is present. Defining ROM_CHECKSUM_EN adds an 8-bit image sum to the exit check.
//
// state  | meaning
// IDLE   | no image yet, waiting for the first download
// LOAD   | download active, bytes written, counted (and summed)
// SETTLE | good image, core held in reset for SETTLE_CYCLES
// RUN    | core released, image valid
// ERROR  | short or corrupt image, core held in reset
module rom_load_ctrl
   import rom_load_pkg::*;
#(
   parameter int unsigned PROG_SIZE     = LLANDER_PROG_SIZE,
   parameter int unsigned VEC_SIZE      = LLANDER_VEC_SIZE,
`ifdef ROM_CHECKSUM_EN
   parameter logic [7:0]  EXPECTED_SUM  = 8'h00,
`endif
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic        clk_25,
   input  logic        RESET_L,
   input  logic        dn_download,
   input  logic        dn_wr,
   input  logic [15:0] dn_addr,
   input  logic [7:0]  dn_data,
   output logic        prog_we,
   output logic        vec_we,
   output logic [12:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        core_reset_l,
   output logic        load_err,
   output logic        loaded
);

   state_t      state, state_nxt;
   logic        dl_q;
   logic        dl_rise, dl_fall;
   logic        prog_hit, vec_hit;
   logic [12:0] local_addr;
   logic        accept;
   logic [15:0] count, count_nxt;
   logic [7:0]  settle_cnt;
   logic        len_ok, sum_ok;

   rom_region_decode #(
      .PROG_SIZE (PROG_SIZE),
      .VEC_SIZE  (VEC_SIZE)
   ) u_decode (
      .addr       (dn_addr),
      .prog_hit   (prog_hit),
      .vec_hit    (vec_hit),
      .local_addr (local_addr)
   );

   assign dl_rise = dn_download & ~dl_q;
   assign dl_fall = ~dn_download & dl_q;
   assign accept  = (state == LOAD) && dn_wr && (prog_hit || vec_hit);

   // A byte arriving with the download fall must count toward the exit decision.
   always_comb begin
      count_nxt = count;
      if (accept && (count != 16'hFFFF)) count_nxt = count + 16'd1;
   end

   assign len_ok = ({16'd0, count_nxt} >= (PROG_SIZE + VEC_SIZE));

`ifdef ROM_CHECKSUM_EN
   logic [7:0] sum, sum_nxt;

   always_comb begin
      sum_nxt = sum;
      if (accept) sum_nxt = sum + dn_data;
   end

   assign sum_ok = (sum_nxt == EXPECTED_SUM);

   always_ff @(posedge clk_25 or negedge RESET_L) begin
      if (!RESET_L) begin
         sum <= 8'd0;
      end else if (state_nxt == LOAD && state != LOAD) begin
         sum <= 8'd0;
      end else begin
         sum <= sum_nxt;
      end
   end
`else
   assign sum_ok = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (dl_rise) state_nxt = LOAD;
         LOAD:    if (dl_fall) state_nxt = (len_ok && sum_ok) ? SETTLE : ERROR;
         SETTLE: begin
            if (dl_rise)              state_nxt = LOAD;
            else if (settle_cnt == 0) state_nxt = RUN;
         end
         RUN:     if (dl_rise) state_nxt = LOAD;
         ERROR:   if (dl_rise) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_25 or negedge RESET_L) begin
      if (!RESET_L) begin
         state        <= IDLE;
         dl_q         <= 1'b0;
         count        <= 16'd0;
         settle_cnt   <= 8'd0;
         prog_we      <= 1'b0;
         vec_we       <= 1'b0;
         rom_addr     <= 13'd0;
         rom_data     <= 8'd0;
         core_reset_l <= 1'b0;
         load_err     <= 1'b0;
         loaded       <= 1'b0;
      end else begin
         state   <= state_nxt;
         dl_q    <= dn_download;
         prog_we <= accept && prog_hit;
         vec_we  <= accept && vec_hit;
         if (accept) begin
            rom_addr <= local_addr;
            rom_data <= dn_data;
         end

         if (state_nxt == LOAD && state != LOAD) count <= 16'd0;
         else                                    count <= count_nxt;

         // Down-counter: loaded with N-1 so SETTLE lasts exactly SETTLE_CYCLES cycles.
         if (state_nxt == SETTLE && state != SETTLE)
            settle_cnt <= 8'(SETTLE_CYCLES - 1);
         else if (state == SETTLE && settle_cnt != 8'd0)
            settle_cnt <= settle_cnt - 8'd1;

         core_reset_l <= (state_nxt == RUN);
         loaded       <= (state_nxt == RUN);
         load_err     <= (state_nxt == ERROR);
      end
   end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed self-checking bench for rom_load_ctrl (default build and ROM_CHECKSUM_EN build).
module tb_rom_load_ctrl;
   import rom_load_pkg::*;

   logic        clk_25 = 1'b0;
   logic        RESET_L;
   logic        dn_download;
   logic        dn_wr;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        prog_we, vec_we;
   logic [12:0] rom_addr;
   logic [7:0]  rom_data;
   logic        core_reset_l, load_err, loaded;

   int passed = 0;
   int total  = 0;
   int n_prog = 0;
   int n_vec  = 0;
   int n_bad  = 0;
   logic [12:0] last_vec = '0;

   always #20 clk_25 = ~clk_25;

   rom_load_ctrl #(
      .SETTLE_CYCLES (16)
`ifdef ROM_CHECKSUM_EN
      , .EXPECTED_SUM (8'h5A)
`endif
   ) dut (
      .clk_25       (clk_25),
      .RESET_L      (RESET_L),
      .dn_download  (dn_download),
      .dn_wr        (dn_wr),
      .dn_addr      (dn_addr),
      .dn_data      (dn_data),
      .prog_we      (prog_we),
      .vec_we       (vec_we),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .core_reset_l (core_reset_l),
      .load_err     (load_err),
      .loaded       (loaded)
   );

   // Image pattern: sums to 8'h5A over bytes 0..10239.
   function automatic logic [7:0] pat(input int a);
      logic [15:0] w;
      logic [7:0]  r;
      w = a[15:0];
      r = w[7:0] + w[15:8] + w[15:8] + w[15:8];
      return (w == 16'd0) ? 8'h5A : r;
   endfunction

   always @(negedge clk_25) begin
      if (prog_we) begin
         n_prog++;
         if (rom_data !== pat(int'(rom_addr))) n_bad++;
      end
      if (vec_we) begin
         n_vec++;
         last_vec = rom_addr;
         if (rom_data !== pat(int'(rom_addr) + 8192)) n_bad++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_25);
      #1;
   endtask

   // Returns with dn_download just lowered (not yet clocked).
   task automatic load(input int n, input bit oor, input bit edge_fall, input int flip);
      dn_download = 1'b1;
      tick();
      check("load_entry", {29'd0, core_reset_l, loaded, load_err}, 32'd0);
      for (int a = 0; a < n; a++) begin
         if (oor && (a == 100 || a == 5000)) begin
            dn_wr   = 1'b1;
            dn_addr = (a == 100) ? 16'd10240 : 16'hFFFF;
            dn_data = 8'hEE;
            tick();
         end
         dn_wr   = 1'b1;
         dn_addr = 16'(a);
         dn_data = pat(a) ^ ((a == flip) ? 8'h01 : 8'h00);
         if (edge_fall && a == n - 1) begin
            dn_download = 1'b0;
            return;
         end
         tick();
      end
      dn_wr       = 1'b0;
      dn_download = 1'b0;
   endtask

   initial begin
      int p0, v0, b0, e;
      RESET_L     = 1'b0;
      dn_download = 1'b0;
      dn_wr       = 1'b0;
      dn_addr     = '0;
      dn_data     = '0;

      // Reset values
      tick(); tick();
      check("rst_we",   {30'd0, prog_we, vec_we}, 32'd0);
      check("rst_addr", {19'd0, rom_addr}, 32'd0);
      check("rst_data", {24'd0, rom_data}, 32'd0);
      check("rst_flags", {29'd0, core_reset_l, loaded, load_err}, 32'd0);
      RESET_L = 1'b1;
      tick(); tick();

      // Full image
      p0 = n_prog; v0 = n_vec; b0 = n_bad;
      load(10240, 1'b0, 1'b0, -1);
      e = 0;
      do begin tick(); e++; end while (core_reset_l !== 1'b1 && e < 40);
      check("full_release_edges", e, 17);
      check("full_prog_cnt", n_prog - p0, 8192);
      check("full_vec_cnt", n_vec - v0, 2048);
      check("full_last_vec", {19'd0, last_vec}, 32'd2047);
      check("full_data", n_bad - b0, 0);
      check("full_flags", {30'd0, loaded, load_err}, 32'd2);

      // Reload from RUN, then async reset mid-LOAD
      dn_download = 1'b1;
      tick();
      check("reload_core_rst", {31'd0, core_reset_l}, 32'd0);
      check("reload_loaded", {31'd0, loaded}, 32'd0);
      for (int a = 0; a < 50; a++) begin
         dn_wr = 1'b1; dn_addr = 16'(a); dn_data = pat(a);
         tick();
      end
      check("pre_rst_we", {31'd0, prog_we}, 32'd1);
      RESET_L = 1'b0; dn_wr = 1'b0; dn_download = 1'b0;
      #1;
      check("midrst_we", {30'd0, prog_we, vec_we}, 32'd0);
      check("midrst_addr", {19'd0, rom_addr}, 32'd0);
      check("midrst_data", {24'd0, rom_data}, 32'd0);
      check("midrst_flags", {29'd0, core_reset_l, loaded, load_err}, 32'd0);
      check("midrst_state", 32'(dut.state), 32'(IDLE));
      tick(); tick();
      RESET_L = 1'b1;
      tick();
      p0 = n_prog;
      dn_wr = 1'b1; dn_addr = 16'd3; dn_data = 8'h11;
      tick();
      dn_wr = 1'b0;
      tick(); tick();
      check("idle_wr_ignored", n_prog - p0, 0);
      check("idle_state", 32'(dut.state), 32'(IDLE));
      check("idle_core_rst", {31'd0, core_reset_l}, 32'd0);

      // Short load
      load(10000, 1'b0, 1'b0, -1);
      tick(); tick(); tick();
      check("short_flags", {29'd0, core_reset_l, loaded, load_err}, 32'd1);
      repeat (20) tick();
      check("short_hold", {29'd0, core_reset_l, loaded, load_err}, 32'd1);

      // Out-of-range bytes do not count: 10239 valid bytes is still short
      p0 = n_prog; v0 = n_vec;
      load(10239, 1'b1, 1'b0, -1);
      tick(); tick();
      check("oor_short_prog", n_prog - p0, 8192);
      check("oor_short_vec", n_vec - v0, 2047);
      check("oor_short_err", {30'd0, loaded, load_err}, 32'd1);

      // Out-of-range bytes in a full load: no writes, load succeeds
      p0 = n_prog; v0 = n_vec; b0 = n_bad;
      load(10240, 1'b1, 1'b0, -1);
      repeat (5) tick();
      check("oor_full_prog", n_prog - p0, 8192);
      check("oor_full_vec", n_vec - v0, 2048);
      check("oor_full_data", n_bad - b0, 0);
      check("oor_full_settle", 32'(dut.state), 32'(SETTLE));
      check("settle_core_rst", {31'd0, core_reset_l}, 32'd0);

      // Rise during SETTLE restarts LOAD; an empty load then fails
      dn_download = 1'b1;
      tick();
      dn_download = 1'b0;
      tick(); tick();
      check("settle_restart", {29'd0, core_reset_l, loaded, load_err}, 32'd1);

      // Last byte written in the same cycle as the fall
      v0 = n_vec;
      load(10240, 1'b0, 1'b1, -1);
      tick();
      dn_wr = 1'b0;
      check("edge_vec_we", {31'd0, vec_we}, 32'd1);
      check("edge_addr", {19'd0, rom_addr}, 32'd2047);
      check("edge_data", {24'd0, rom_data}, {24'd0, pat(10239)});
      e = 1;
      do begin tick(); e++; end while (core_reset_l !== 1'b1 && e < 40);
      check("edge_release_edges", e, 17);
      check("edge_vec_cnt", n_vec - v0, 2048);
      check("edge_flags", {30'd0, loaded, load_err}, 32'd2);

      // dn_wr in RUN is ignored
      p0 = n_prog;
      dn_wr = 1'b1; dn_addr = 16'd10; dn_data = 8'h77;
      tick(); tick(); tick();
      dn_wr = 1'b0;
      tick(); tick();
      check("run_wr_ignored", n_prog - p0, 0);
      check("run_core_rst", {31'd0, core_reset_l}, 32'd1);

      // One flipped byte: rejected only when the checksum is built
      b0 = n_bad;
      load(10240, 1'b0, 1'b0, 5);
      repeat (20) tick();
      check("flip_data_seen", n_bad - b0, 1);
`ifdef ROM_CHECKSUM_EN
      check("flip_flags", {29'd0, core_reset_l, loaded, load_err}, 32'd1);
`else
      check("flip_flags", {29'd0, core_reset_l, loaded, load_err}, 32'd6);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rom_load_ctrl.md
# rom_load_ctrl

Sequences the HPS ROM download into the Lunar Lander core's program and vector ROMs, owns the ROM write port, and holds the game core in reset until a complete, validated image is present. Sits between the hps_io download stream and the core's ROM write ports, and drives the core's active-low reset. It replaces ad-hoc "reset while downloading" gating with an explicit load/settle/run sequence.

## Interface
Parameters:
- PROG_SIZE, 8192: program ROM bytes, mapped at download address 0.
- VEC_SIZE, 2048: vector ROM bytes, mapped at download address PROG_SIZE.
- SETTLE_CYCLES, 16: clk_25 cycles held in reset after a good load. Range 1..255.
- EXPECTED_SUM, 8'h00: 8-bit modular sum of the full image. Used only with ROM_CHECKSUM_EN.

Ports:
- clk_25  in  1  system clock; one clock domain.
- RESET_L  in  1  asynchronous, active-low reset.
- dn_download  in  1  download active, level.
- dn_wr  in  1  one-cycle byte strobe.
- dn_addr  in  16  download byte address.
- dn_data  in  8  download byte.
- prog_we  out  1  program ROM write enable.
- vec_we  out  1  vector ROM write enable.
- rom_addr  out  13  region-local write address.
- rom_data  out  8  write data.
- core_reset_l  out  1  core reset, active-low.
- load_err  out  1  last load was short or failed checksum. Sticky until the next load starts.
- loaded  out  1  a valid image is present.

## Operation
- States: IDLE, LOAD, SETTLE, RUN, ERROR.
- Reset values: state IDLE. prog_we, vec_we, loaded, load_err and core_reset_l are all 0. rom_addr and rom_data are 0. The byte count and the sum are 0.
- IDLE: waits for the first image. On a dn_download rise it goes to LOAD.
- LOAD:
  - core_reset_l is 0.
  - Entering LOAD clears the count, the sum and load_err.
  - Each dn_wr with dn_addr < PROG_SIZE pulses prog_we, with rom_addr = dn_addr[12:0].
  - Each dn_wr with PROG_SIZE ≤ dn_addr < PROG_SIZE+VEC_SIZE pulses vec_we, with rom_addr = dn_addr − PROG_SIZE.
  - Addresses at or above PROG_SIZE+VEC_SIZE are ignored. They produce no write and are not counted.
  - Accepted bytes increment a 16-bit saturating count and are added into an 8-bit wrapping sum.
- LOAD exit, on a dn_download fall:
  - If count < PROG_SIZE+VEC_SIZE, go to ERROR.
  - Otherwise go to SETTLE.
- SETTLE: core_reset_l stays 0 for SETTLE_CYCLES cycles. Then loaded←1 and the block goes to RUN.
- RUN: core_reset_l=1. A dn_download rise goes to LOAD and clears loaded.
- ERROR: load_err=1, loaded=0, core_reset_l=0. A dn_download rise goes to LOAD.
- Duplicate bytes to the same address overwrite and count again. The count can therefore be met with holes in the image; this is accepted behaviour.
- dn_wr while not in LOAD is ignored.

## Timing
- Write latency is 1 cycle. dn_wr in cycle n produces prog_we or vec_we, rom_addr and rom_data registered in cycle n+1. The write-enable is a single-cycle pulse.
- State transitions are registered. core_reset_l goes low the cycle after a dn_download rise.
- dn_wr in the same cycle as the dn_download fall: the byte is written and counted, and that count is used for the exit decision.
- Back-to-back dn_wr (every cycle) is supported with no stalls.
- Leaving SETTLE: core_reset_l rises exactly SETTLE_CYCLES+1 cycles after the dn_download fall.
- Asynchronous RESET_L assertion in any state forces the reset values immediately. The image is then considered absent, and the block waits in IDLE for a new download.
- A dn_download rise during SETTLE restarts LOAD.

## Configuration
- ROM_CHECKSUM_EN defined:
  - The LOAD exit additionally requires sum == EXPECTED_SUM.
  - A mismatch goes to ERROR.
- ROM_CHECKSUM_EN undefined:
  - The sum register is not built.
  - Only the length check applies.

## Structure
- Package rom_load_pkg holds the state enum (IDLE, LOAD, SETTLE, RUN, ERROR) and the localparams LLANDER_PROG_SIZE and LLANDER_VEC_SIZE, shared with the core ROM instantiation.
- One sub-module, rom_region_decode: combinational dn_addr → {prog_hit, vec_hit, local_addr}.
- Everything else stays flat in rom_load_ctrl.

## Test plan
- Full image: stream 10240 bytes at addresses 0..10239, one per cycle, then drop dn_download. Expect 8192 prog_we and 2048 vec_we pulses. The last vec_we has rom_addr 2047. core_reset_l rises 17 cycles after the fall; loaded=1, load_err=0.
- Short load: stream 10000 bytes. Expect ERROR: load_err=1, loaded=0, core_reset_l held 0.
- Out-of-range addresses: write addr 10240 and 16'hFFFF during an otherwise full load. Expect no write-enable pulses for those bytes and an unchanged count; the load succeeds.
- Edge write: a dn_wr in the same cycle as the dn_download fall with byte 10239 completes the image. Expect vec_we the next cycle, then SETTLE.
- Reload and mid-op reset:
  - From RUN, raise dn_download. core_reset_l goes low the next cycle.
  - Assert RESET_L mid-LOAD. All outputs return to 0 immediately and the state is IDLE.
- With ROM_CHECKSUM_EN and EXPECTED_SUM=8'h5A: a full image summing to 8'h5A reaches RUN. Flipping one byte gives ERROR with load_err=1.
